// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared types and constants for the parametrised decimal
//               calculator: command codes, status codes, FSM state
//               encoding, active-low 7-segment patterns and the digit lookup.
// Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

  // Digit commands are the plain values 0..9; only the operators are named.
  typedef enum logic [3:0] {
    CMD_ADD = 4'b1010,
    CMD_SUB = 4'b1011,
    CMD_MUL = 4'b1100,
    CMD_DIV = 4'b1101,
    CMD_EQ  = 4'b1110,
    CMD_CLR = 4'b1111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'b00,
    ST_BUSY   = 2'b01,
    ST_ERROR  = 2'b10,
    ST_RESULT = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_ENTRY_A = 3'd0,
    S_ENTRY_B = 3'd1,
    S_CALC    = 3'd2,
    S_CONV    = 3'd3,
    S_RESULT  = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_engine_param_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter. The first
//               shift happens on the start edge, so done is raised after
//               exactly W shift cycles.
// Ports       : clock, reset (async active-low), start, bin[W-1:0] ->
//               busy, done (1-cycle pulse), bcd[4*N_DIGITS-1:0]
// Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int W        = 27,
  parameter int N_DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_sh;
  logic [CW-1:0] r_cnt;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in a bit.
  function automatic logic [4*N_DIGITS-1:0] dabble(input logic [4*N_DIGITS-1:0] b,
                                                   input logic bit_in);
    logic [4*N_DIGITS-1:0] t;
    t = b;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
    end
    return {t[4*N_DIGITS-2:0], bit_in};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sh  <= '0;
      r_cnt <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd   <= dabble('0, bin[W-1]);
        r_sh  <= {bin[W-2:0], 1'b0};
        r_cnt <= CW'(W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        bcd   <= dabble(bcd, r_sh[W-1]);
        r_sh  <= {r_sh[W-2:0], 1'b0};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_engine_param.sv
`default_nettype none
// ============================================================================
// Module      : calc_engine_param
// Description : Parametrised decimal calculator core. Sign-magnitude add,
//               subtract and shift-add multiply, sequential BCD conversion and
//               active-low 7-segment output, with a valid/ready command port.
//               Optional macro CALC_DIV_EN adds restoring signed division on
//               command 1101; without it 1101 is accepted and ignored.
// Ports       : clock, reset (async active-low), cmd[3:0], cmd_valid ->
//               cmd_ready, displays[N_DIGITS-1:0][6:0], status[1:0]
// Revision    : 1.0  initial release
// ============================================================================
module calc_engine_param
  import calc_pkg::*;
#(
  parameter int N_DIGITS = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [3:0]                   cmd,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  output logic [N_DIGITS-1:0][6:0]     displays,
  output logic [1:0]                   status
);

  localparam int W  = $clog2(10**N_DIGITS);
  localparam int CW = $clog2(W + 1);
  localparam logic [2*W-1:0] c_max_pos = (2*W)'(10**N_DIGITS - 1);
  localparam logic [2*W-1:0] c_max_neg = (2*W)'(10**(N_DIGITS-1) - 1);

  state_e                r_state;
  cmd_e                  r_op;
  logic [W-1:0]          r_entry, r_a_mag, r_b_mag, r_res_mag, r_sh;
  logic [4*N_DIGITS-1:0] r_entry_bcd, r_res_bcd;
  logic [3:0]            r_ndig;
  logic                  r_a_neg, r_res_neg, r_ovf, r_go;
  logic [2*W-1:0]        r_prod;
  logic [CW-1:0]         r_cnt;

  logic                  w_acc, w_is_digit, w_is_op, w_sb, w_as_neg;
  logic [W:0]            w_as_mag;
  logic [2*W-1:0]        w_prod_nxt, w_calc_mag;
  logic                  w_calc_done, w_calc_neg, w_calc_err, w_fin_neg, w_calc_ovf;
  logic                  w_conv_busy, w_conv_done;
  logic [4*N_DIGITS-1:0] w_conv_bcd, w_disp_bcd;
  logic                  w_disp_neg;
  int                    w_msd;

`ifdef CALC_DIV_EN
  logic [W-1:0]          r_rem, w_rem_nxt, w_quo_nxt;
  logic [W:0]            w_trial;
  logic                  w_qbit;
`endif

  assign cmd_ready  = (r_state != S_CALC) && (r_state != S_CONV);
  assign w_acc      = cmd_valid && cmd_ready;
  assign w_is_digit = (cmd <= 4'd9);
`ifdef CALC_DIV_EN
  assign w_is_op    = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL) || (cmd == CMD_DIV);
`else
  assign w_is_op    = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);
`endif

  // B is always a freshly entered, non-negative value, so subtraction only
  // flips B's sign and the product/quotient sign is simply A's sign.
  always_comb begin
    w_sb = (r_op == CMD_SUB);
    if (r_a_neg == w_sb) begin
      w_as_mag = {1'b0, r_a_mag} + {1'b0, r_b_mag};
      w_as_neg = r_a_neg;
    end else if (r_a_mag >= r_b_mag) begin
      w_as_mag = {1'b0, r_a_mag - r_b_mag};
      w_as_neg = r_a_neg;
    end else begin
      w_as_mag = {1'b0, r_b_mag - r_a_mag};
      w_as_neg = w_sb;
    end
  end

  // MSB-first shift-add: prod = 2*prod + (multiplier bit ? A : 0).
  assign w_prod_nxt = {r_prod[2*W-2:0], 1'b0} + (r_sh[W-1] ? {{W{1'b0}}, r_a_mag} : '0);

`ifdef CALC_DIV_EN
  // Restoring division: the quotient bits shift into r_sh as the dividend shifts out.
  assign w_trial   = {r_rem, r_sh[W-1]};
  assign w_qbit    = (w_trial >= {1'b0, r_b_mag});
  assign w_rem_nxt = w_qbit ? W'(w_trial - {1'b0, r_b_mag}) : w_trial[W-1:0];
  assign w_quo_nxt = {r_sh[W-2:0], w_qbit};
`endif

  always_comb begin
    w_calc_done = 1'b0;
    w_calc_mag  = '0;
    w_calc_neg  = 1'b0;
    w_calc_err  = 1'b0;
    if (r_state == S_CALC) begin
      if (r_op == CMD_MUL) begin
        w_calc_done = (r_cnt == CW'(1));
        w_calc_mag  = w_prod_nxt;
        w_calc_neg  = r_a_neg;
`ifdef CALC_DIV_EN
      end else if (r_op == CMD_DIV) begin
        w_calc_done = (r_cnt == CW'(1));
        w_calc_mag  = {{W{1'b0}}, w_quo_nxt};
        w_calc_neg  = r_a_neg;
        w_calc_err  = (r_b_mag == '0);
`endif
      end else begin
        w_calc_done = 1'b1;
        w_calc_mag  = {{(W-1){1'b0}}, w_as_mag};
        w_calc_neg  = w_as_neg;
      end
    end
  end

  // A zero result is always shown unsigned; negatives need a digit for the minus.
  assign w_fin_neg  = w_calc_neg && (w_calc_mag != '0);
  assign w_calc_ovf = w_calc_err || (w_fin_neg ? (w_calc_mag > c_max_neg) : (w_calc_mag > c_max_pos));

  bin2bcd_seq #(.W(W), .N_DIGITS(N_DIGITS)) u_conv (
    .clock (clock),
    .reset (reset),
    .start (r_go && !w_conv_busy),
    .bin   (r_res_mag),
    .busy  (w_conv_busy),
    .done  (w_conv_done),
    .bcd   (w_conv_bcd)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_ENTRY_A;  r_op <= CMD_ADD;
      r_entry <= '0;  r_entry_bcd <= '0;  r_ndig <= '0;
      r_a_mag <= '0;  r_a_neg <= 1'b0;  r_b_mag <= '0;
      r_res_mag <= '0;  r_res_neg <= 1'b0;  r_res_bcd <= '0;
      r_ovf <= 1'b0;  r_go <= 1'b0;  r_prod <= '0;  r_sh <= '0;  r_cnt <= '0;
`ifdef CALC_DIV_EN
      r_rem <= '0;
`endif
    end else begin
      r_go <= 1'b0;
      case (r_state)
        S_CALC: begin
          if (r_op == CMD_MUL) begin
            r_prod <= w_prod_nxt;
            r_sh   <= {r_sh[W-2:0], 1'b0};
            r_cnt  <= r_cnt - CW'(1);
`ifdef CALC_DIV_EN
          end else if (r_op == CMD_DIV) begin
            r_rem  <= w_rem_nxt;
            r_sh   <= w_quo_nxt;
            r_cnt  <= r_cnt - CW'(1);
`endif
          end
          if (w_calc_done) begin
            r_res_mag <= w_calc_mag[W-1:0];
            r_res_neg <= w_fin_neg;
            r_ovf     <= w_calc_ovf;
            r_go      <= 1'b1;
            r_state   <= S_CONV;
          end
        end
        S_CONV: begin
          if (w_conv_done) begin
            r_res_bcd <= w_conv_bcd;
            r_state   <= r_ovf ? S_ERROR : S_RESULT;
          end
        end
        default: begin
          if (w_acc && (cmd == CMD_CLR)) begin
            r_state <= S_ENTRY_A;
            r_entry <= '0;  r_entry_bcd <= '0;  r_ndig <= '0;
            r_a_mag <= '0;  r_a_neg <= 1'b0;  r_b_mag <= '0;
            r_res_mag <= '0;  r_res_neg <= 1'b0;  r_res_bcd <= '0;  r_ovf <= 1'b0;
          end else if (w_acc && (r_state != S_ERROR)) begin
            if (w_is_digit) begin
              if (r_state == S_RESULT) begin
                r_entry     <= W'(cmd);
                r_entry_bcd <= (4*N_DIGITS)'(cmd);
                r_ndig      <= 4'd1;
                r_state     <= S_ENTRY_A;
              end else if (r_ndig < 4'(N_DIGITS)) begin
                r_entry     <= W'(r_entry * W'(10)) + W'(cmd);
                r_entry_bcd <= {r_entry_bcd[4*N_DIGITS-5:0], cmd};
                r_ndig      <= r_ndig + 4'd1;
              end
            end else if (w_is_op) begin
              if (r_state == S_ENTRY_B) begin
                if (r_ndig == 4'd0) r_op <= cmd_e'(cmd);
              end else begin
                r_a_mag     <= (r_state == S_RESULT) ? r_res_mag : r_entry;
                r_a_neg     <= (r_state == S_RESULT) && r_res_neg;
                r_op        <= cmd_e'(cmd);
                r_entry     <= '0;  r_entry_bcd <= '0;  r_ndig <= '0;
                r_state     <= S_ENTRY_B;
              end
            end else if ((cmd == CMD_EQ) && (r_state == S_ENTRY_B)) begin
              r_b_mag <= r_entry;
              r_prod  <= '0;
              r_cnt   <= CW'(W);
`ifdef CALC_DIV_EN
              r_rem   <= '0;
              r_sh    <= (r_op == CMD_DIV) ? r_a_mag : r_entry;
`else
              r_sh    <= r_entry;
`endif
              r_state <= S_CALC;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    case (r_state)
      S_CALC, S_CONV: status = ST_BUSY;
      S_ERROR:        status = ST_ERROR;
      S_RESULT:       status = ST_RESULT;
      default:        status = ST_ENTRY;
    endcase
  end

  assign w_disp_bcd = (r_state == S_RESULT) ? r_res_bcd : r_entry_bcd;
  assign w_disp_neg = (r_state == S_RESULT) && r_res_neg;

  // Digits above the most significant non-zero digit are blanked; digit 0 always shows.
  always_comb begin
    w_msd = 0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_disp_bcd[4*i +: 4] != 4'd0) w_msd = i;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      displays[i] = SEG_BLANK;
      if (r_state == S_ERROR) begin
        if (i == 0) displays[i] = SEG_E;
      end else if (i <= w_msd) begin
        displays[i] = seg7(w_disp_bcd[4*i +: 4]);
      end else if (w_disp_neg && (i == w_msd + 1)) begin
        displays[i] = SEG_MINUS;
      end
    end
  end

endmodule
`default_nettype wire
